exp_product: RTL

EXP_PRODUCT -- requirements
Module: exp_product

---
 rtl/exp_pkg.sv | 17 +
 rtl/q_mul.sv | 37 +++
 rtl/exp_product.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// Shared constants and state encoding for the e^X factor-product block.
package exp_pkg;

  localparam int DATA_W   = 26;   // Q15.11 unsigned factor/result width
  localparam int FRAC_W   = 11;   // fraction bits
  localparam int NUM_FACT = 6;    // factors multiplied per product
  localparam int Q_ONE    = 2048; // 1.0 in Q15.11

  // Index of the last factor; reaching it finishes the product.
  localparam logic [2:0] LAST_STEP = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/q_mul.sv
// Combinational unsigned fixed-point multiply: round half up, then saturate.
module q_mul #(
  parameter int DATA_W = 26,
  parameter int FRAC_W = 11
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] p_o,
  output logic              sat_o
);

  // Half an output LSB, added before truncation so ties round upward.
  localparam logic [2*DATA_W-1:0] RND = (2*DATA_W)'(1'b1) << (FRAC_W-1);

  logic [2*DATA_W-1:0] full_s;
  logic [2*DATA_W-1:0] rnd_s;
  logic [2*DATA_W-1:0] shifted_s;

  // The rounded sum cannot wrap: (2^W-1)^2 + 2^(F-1) stays below 2^(2W).
  assign full_s    = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
  assign rnd_s     = full_s + RND;
  assign shifted_s = rnd_s >> FRAC_W;

  // Clamp to all-ones when any bit above the result width survives the shift.
  always_comb begin
    p_o   = '0;
    sat_o = 1'b0;
    if (|shifted_s[2*DATA_W-1:DATA_W]) begin
      p_o   = '1;
      sat_o = 1'b1;
    end else begin
      p_o   = shifted_s[DATA_W-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/exp_product.sv
// Sequential product of six Q15.11 factors using one shared q_mul, one step per cycle.
module exp_product #(
  parameter int DATA_W = exp_pkg::DATA_W,
  parameter int FRAC_W = exp_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mul_valid,
  input  logic [DATA_W-1:0] multiplier_0,
  input  logic [DATA_W-1:0] multiplier_1,
  input  logic [DATA_W-1:0] multiplier_2,
  input  logic [DATA_W-1:0] multiplier_3,
  input  logic [DATA_W-1:0] multiplier_4,
  input  logic [DATA_W-1:0] multiplier_5,
  output logic              O_valid,
  output logic [DATA_W-1:0] O_result,
  output logic              O_sat,
  output logic              busy,
  output logic              drop
);

  import exp_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] fact_q [NUM_FACT];
  logic [DATA_W-1:0] fact_d [NUM_FACT];
  logic              sat_q, sat_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              osat_q, osat_d;
  logic              drop_q, drop_d;

  logic [DATA_W-1:0] fact_sel_s;
  logic [DATA_W-1:0] prod_s;
  logic              prod_sat_s;

  // Pick the latched factor for the current step.
  always_comb begin
    fact_sel_s = '0;
    case (step_q)
      3'd0:    fact_sel_s = fact_q[0];
      3'd1:    fact_sel_s = fact_q[1];
      3'd2:    fact_sel_s = fact_q[2];
      3'd3:    fact_sel_s = fact_q[3];
      3'd4:    fact_sel_s = fact_q[4];
      3'd5:    fact_sel_s = fact_q[5];
      default: fact_sel_s = '0;
    endcase
  end

  q_mul #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_q_mul (
    .a_i   (acc_q),
    .b_i   (fact_sel_s),
    .p_o   (prod_s),
    .sat_o (prod_sat_s)
  );

  // Next-state logic: accept in IDLE, one multiply per cycle in MUL, drop overlaps.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    fact_d  = fact_q;
    sat_d   = sat_q;
    res_d   = res_q;
    osat_d  = osat_q;
    valid_d = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_valid) begin
          fact_d[0] = multiplier_0;
          fact_d[1] = multiplier_1;
          fact_d[2] = multiplier_2;
          fact_d[3] = multiplier_3;
          fact_d[4] = multiplier_4;
          fact_d[5] = multiplier_5;
          acc_d     = multiplier_0;
          sat_d     = 1'b0;
          step_d    = 3'd1;
          state_d   = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        drop_d = mul_valid;
        acc_d  = prod_s;
        sat_d  = sat_q | prod_sat_s;
        if (step_q == LAST_STEP) begin
          res_d   = prod_s;
          osat_d  = sat_q | prod_sat_s;
          valid_d = 1'b1;
          step_d  = 3'd0;
          state_d = ST_IDLE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: begin
        step_d  = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      acc_q   <= '0;
      for (int i = 0; i < NUM_FACT; i++) begin
        fact_q[i] <= '0;
      end
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      osat_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      fact_q  <= fact_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      osat_q  <= osat_d;
      drop_q  <= drop_d;
    end
  end

  assign O_valid  = valid_q;
  assign O_result = res_q;
  assign O_sat    = osat_q;
  assign drop     = drop_q;
  assign busy     = (state_q == ST_MUL);

endmodule
